// File: rtl/irq_arbiter_ctrl_pkg.sv
// Shared constants and state encoding for the interrupt request front end.
package irq_arbiter_ctrl_pkg;

  localparam int NUM_IRQ = 8;
  localparam int VEC_W   = $clog2(NUM_IRQ);

  // The unused encoding 2'd3 is treated as illegal and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_arbiter_ctrl_prio_pick.sv
// Combinational priority picker: the highest set bit of cand wins.
module irq_prio_pick
  import irq_arbiter_ctrl_pkg::*;
(
  input  logic [NUM_IRQ-1:0] cand,
  output logic [VEC_W-1:0]   sel,
  output logic               any_vld
);

  // Scan upward so the highest-index candidate is assigned last.
  always_comb begin
    // NOTE: assign every output a default before any conditional logic, otherwise a latch is inferred.
    sel     = '0;
    any_vld = |cand;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cand[i]) sel = i[VEC_W-1:0];
    end
  end

endmodule

// File: rtl/irq_arbiter_ctrl.sv
// Interrupt request front end: capture, mask, priority select, and
// valid/ack handshake with an end-of-interrupt hold-off.
module irq_arbiter_ctrl
  import irq_arbiter_ctrl_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] mask,
  output logic [VEC_W-1:0]   vec,
  output logic               vld,
  input  logic               ack,
  input  logic               eoi,
  output logic               busy,
  output logic [NUM_IRQ-1:0] pending
);

  state_t             state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] set_bits;
  logic [NUM_IRQ-1:0] clr_bits;
  logic [NUM_IRQ-1:0] cand;
  logic [VEC_W-1:0]   sel;
  logic               any_vld;

  // Set and clear requests for the pending register.
  always_comb begin
    set_bits = '0;
    clr_bits = '0;
    if (en) set_bits = EDGE_MODE ? (irq & ~irq_q) : irq;
    if (state == PRESENT && ack) clr_bits[vec] = 1'b1;
  end

  assign cand = pending & ~mask;

  irq_prio_pick u_pick (
    .cand    (cand),
    .sel     (sel),
    .any_vld (any_vld)
  );

  // Capture registers; a new edge wins over a simultaneous ack-clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr_bits) | set_bits;
    end
  end

  // Grant state machine with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec   <= '0;
      vld   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && any_vld) begin
            vec   <= sel;
            vld   <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack) begin
            vld   <= 1'b0;
            busy  <= 1'b1;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          vld   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_arbiter_ctrl.sv
// Directed bench for irq_arbiter_ctrl with hand-computed expectations.
module tb_irq_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, ack, eoi;
  logic [7:0] irq, mask, pending;
  logic [2:0] vec;
  logic       vld, busy;

  int total = 0;
  int bad   = 0;

  irq_arbiter_ctrl #(.EDGE_MODE(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .irq     (irq),
    .mask    (mask),
    .vec     (vec),
    .vld     (vld),
    .ack     (ack),
    .eoi     (eoi),
    .busy    (busy),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic v, input logic [2:0] vv,
                    input logic b, input logic [7:0] p);
    check({tag, ".vld"}, 32'(vld), 32'(v));
    if (v) check({tag, ".vec"}, 32'(vec), 32'(vv));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".pend"}, 32'(pending), 32'(p));
  endtask

  initial begin
    rst = 1; en = 1; ack = 0; eoi = 0; irq = 0; mask = 0;
    tick(); tick();
    check("rst.vec", 32'(vec), 0);
    st("rst", 0, 0, 0, 8'h00);
    rst = 0;
    tick();

    // Single request, two-cycle latency.
    irq = 8'h10; tick(); irq = 0;
    st("single.cap", 0, 0, 0, 8'h10);
    tick(); st("single.grant", 1, 4, 0, 8'h10);
    tick(); st("single.hold", 1, 4, 0, 8'h10);
    ack = 1; tick(); ack = 0;
    st("single.ack", 0, 0, 1, 8'h00);
    tick(); st("single.svc", 0, 0, 1, 8'h00);
    eoi = 1; tick(); eoi = 0;
    st("single.eoi", 0, 0, 0, 8'h00);

    // Priority, no preemption.
    irq = 8'h05; tick(); irq = 0;
    tick(); st("prio.grant2", 1, 2, 0, 8'h05);
    irq = 8'h80; tick(); irq = 0;
    st("prio.nopreempt", 1, 2, 0, 8'h85);
    ack = 1; tick(); ack = 0;
    st("prio.ack2", 0, 0, 1, 8'h81);
    eoi = 1; tick(); eoi = 0;
    tick(); st("prio.grant7", 1, 7, 0, 8'h81);
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    tick(); st("prio.grant0", 1, 0, 0, 8'h01);
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    st("prio.done", 0, 0, 0, 8'h00);

    // Masking retains pending bits.
    mask = 8'h80;
    irq = 8'h81; tick(); irq = 0;
    tick(); st("mask.grant0", 1, 0, 0, 8'h81);
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    tick(); st("mask.held", 0, 0, 0, 8'h80);
    mask = 8'h00; tick();
    st("mask.grant7", 1, 7, 0, 8'h80);
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;

    // Simultaneous set and clear: set wins.
    irq = 8'h08; tick(); irq = 0;
    tick(); st("sc.grant3", 1, 3, 0, 8'h08);
    ack = 1; irq = 8'h08; tick(); ack = 0; irq = 0;
    st("sc.setwins", 0, 0, 1, 8'h08);
    eoi = 1; tick(); eoi = 0;
    tick(); st("sc.regrant3", 1, 3, 0, 8'h08);
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;

    // en=0 blocks capture; stray handshakes ignored.
    en = 0; irq = 8'hff; tick(); irq = 0;
    tick(); st("en0", 0, 0, 0, 8'h00);
    en = 1;
    ack = 1; tick(); ack = 0;
    st("stray.ack", 0, 0, 0, 8'h00);
    irq = 8'h01; tick(); irq = 0;
    tick(); st("stray.grant0", 1, 0, 0, 8'h01);
    eoi = 1; tick(); eoi = 0;
    st("stray.eoi", 1, 0, 0, 8'h01);
    en = 0; tick();
    st("en0.present", 1, 0, 0, 8'h01);
    en = 1;
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;

    // Reset mid-handshake.
    irq = 8'h22; tick(); irq = 0;
    tick(); st("rstmid.grant5", 1, 5, 0, 8'h22);
    rst = 1; tick(); rst = 0;
    check("rstmid.vec", 32'(vec), 0);
    st("rstmid", 0, 0, 0, 8'h00);
    tick(); tick();
    st("rstmid.nogrant", 0, 0, 0, 8'h00);
    irq = 8'h02; tick(); irq = 0;
    tick(); st("rstmid.fresh", 1, 1, 0, 8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
